// File: rtl/hack_alu_pkg.sv
// Shared definitions for the Hack ALU: data width, control word layout and canonical opcodes.
package hack_alu_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  // Field order matches the Hack instruction c-bits a..f: {zx, nx, zy, ny, f, no}.
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam alu_ctrl_t OP_ZERO    = 6'b101010;
  localparam alu_ctrl_t OP_ONE     = 6'b111111;
  localparam alu_ctrl_t OP_NEG_ONE = 6'b111010;
  localparam alu_ctrl_t OP_X       = 6'b001100;
  localparam alu_ctrl_t OP_Y       = 6'b110000;
  localparam alu_ctrl_t OP_NOT_X   = 6'b001101;
  localparam alu_ctrl_t OP_NOT_Y   = 6'b110001;
  localparam alu_ctrl_t OP_NEG_X   = 6'b001111;
  localparam alu_ctrl_t OP_NEG_Y   = 6'b110011;
  localparam alu_ctrl_t OP_X_INC   = 6'b011111;
  localparam alu_ctrl_t OP_Y_INC   = 6'b110111;
  localparam alu_ctrl_t OP_X_DEC   = 6'b001110;
  localparam alu_ctrl_t OP_Y_DEC   = 6'b110010;
  localparam alu_ctrl_t OP_ADD     = 6'b000010;
  localparam alu_ctrl_t OP_X_SUB_Y = 6'b010011;
  localparam alu_ctrl_t OP_Y_SUB_X = 6'b000111;
  localparam alu_ctrl_t OP_AND     = 6'b000000;
  localparam alu_ctrl_t OP_OR      = 6'b010101;

  function automatic alu_ctrl_t pack_ctrl(input logic zx, input logic nx, input logic zy,
                                          input logic ny, input logic f, input logic no);
    alu_ctrl_t c;
    c.zx = zx;
    c.nx = nx;
    c.zy = zy;
    c.ny = ny;
    c.f  = f;
    c.no = no;
    return c;
  endfunction

endpackage

// File: rtl/hack_alu_core.sv
// Purely combinational Hack ALU datapath: operand conditioning, add/AND, output invert and flags.
module hack_alu_core
  import hack_alu_pkg::*;
(
  input  logic [WORD_W-1:0] x_i,
  input  logic [WORD_W-1:0] y_i,
  input  alu_ctrl_t         ctrl_i,
  output logic [WORD_W-1:0] out_o,
  output logic              zr_o,
  output logic              ng_o
);

  word_t x1, x2, y1, y2, sum, r, res;

  always_comb begin
    x1  = ctrl_i.zx ? '0 : x_i;
    x2  = ctrl_i.nx ? ~x1 : x1;
    y1  = ctrl_i.zy ? '0 : y_i;
    y2  = ctrl_i.ny ? ~y1 : y1;
    // Carry out is intentionally dropped; the Hack ISA has no overflow flag.
    sum = x2 + y2;
    r   = ctrl_i.f ? sum : (x2 & y2);
    res = ctrl_i.no ? ~r : r;
  end

  assign out_o = res;
  assign zr_o  = (res == '0);
  assign ng_o  = res[WORD_W-1];

endmodule

// File: rtl/hack_alu.sv
// Hack ALU top. Combinational by default; define HACK_ALU_OUT_REG_EN to register out/zr/ng.
module hack_alu
  import hack_alu_pkg::*;
(
  input  logic              clk_cpu,
  input  logic              rst,
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic              zx,
  input  logic              nx,
  input  logic              zy,
  input  logic              ny,
  input  logic              f,
  input  logic              no,
  output logic [WORD_W-1:0] out,
  output logic              zr,
  output logic              ng
);

  alu_ctrl_t         ctrl;
  logic [WORD_W-1:0] core_out;
  logic              core_zr;
  logic              core_ng;

  assign ctrl = pack_ctrl(zx, nx, zy, ny, f, no);

  hack_alu_core u_core (
    .x_i   (x),
    .y_i   (y),
    .ctrl_i(ctrl),
    .out_o (core_out),
    .zr_o  (core_zr),
    .ng_o  (core_ng)
  );

`ifdef HACK_ALU_OUT_REG_EN
  logic [WORD_W-1:0] out_d, out_q;
  logic              zr_d, zr_q;
  logic              ng_d, ng_q;

  // Reset value reflects a zero result so the flags stay consistent with out.
  always_comb begin
    out_d = core_out;
    zr_d  = core_zr;
    ng_d  = core_ng;
    if (rst) begin
      out_d = '0;
      zr_d  = 1'b1;
      ng_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_cpu) begin
    out_q <= out_d;
    zr_q  <= zr_d;
    ng_q  <= ng_d;
  end

  assign out = out_q;
  assign zr  = zr_q;
  assign ng  = ng_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk_cpu ^ rst;

  assign out = core_out;
  assign zr  = core_zr;
  assign ng  = core_ng;
`endif

endmodule

// File: tb/tb_hack_alu.sv
// Directed and sweep bench for hack_alu; covers the registered build when HACK_ALU_OUT_REG_EN is set.
module tb_hack_alu;
  import hack_alu_pkg::*;

  logic        clk_cpu = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        zx = 1'b0, nx = 1'b0, zy = 1'b0, ny = 1'b0, f = 1'b0, no = 1'b0;
  logic [15:0] out;
  logic        zr, ng;

  int total = 0;
  int bad = 0;

  always #5 clk_cpu = ~clk_cpu;

  hack_alu dut (
    .clk_cpu(clk_cpu),
    .rst    (rst),
    .x      (x),
    .y      (y),
    .zx     (zx),
    .nx     (nx),
    .zy     (zy),
    .ny     (ny),
    .f      (f),
    .no     (no),
    .out    (out),
    .zr     (zr),
    .ng     (ng)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  c;
    logic [15:0] e_out;
    logic        e_zr;
    logic        e_ng;
    string       name;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [5:0] c);
    logic [15:0] ta, tb, tr;
    ta = c[5] ? 16'h0000 : a;
    if (c[4]) ta = ~ta;
    tb = c[3] ? 16'h0000 : b;
    if (c[2]) tb = ~tb;
    tr = c[1] ? 16'(ta + tb) : (ta & tb);
    if (c[0]) tr = ~tr;
    return tr;
  endfunction

  task automatic check(input string name, input logic [15:0] e_out, input logic e_zr,
                       input logic e_ng);
    total++;
    if (out !== e_out || zr !== e_zr || ng !== e_ng) begin
      bad++;
      $display("FAIL %s: got out=%h zr=%b ng=%b, want out=%h zr=%b ng=%b",
               name, out, zr, ng, e_out, e_zr, e_ng);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
    x = a;
    y = b;
    {zx, nx, zy, ny, f, no} = c;
  endtask

  // Drive after the falling edge; sample 1 ns after the edge that makes the result visible.
  task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
    @(negedge clk_cpu);
    drive(a, b, c);
`ifdef HACK_ALU_OUT_REG_EN
    @(posedge clk_cpu);
`endif
    #1;
  endtask

  initial begin
    logic [15:0] rx, ry, m;

    vecs[0]  = '{16'h1234, 16'h5678, OP_ZERO,    16'h0000, 1'b1, 1'b0, "const0"};
    vecs[1]  = '{16'h1234, 16'h5678, OP_ONE,     16'h0001, 1'b0, 1'b0, "const1"};
    vecs[2]  = '{16'h1234, 16'h5678, OP_NEG_ONE, 16'hFFFF, 1'b0, 1'b1, "const_m1"};
    vecs[3]  = '{16'h1234, 16'h5678, OP_X,       16'h1234, 1'b0, 1'b0, "pass_x"};
    vecs[4]  = '{16'h1234, 16'h5678, OP_Y,       16'h5678, 1'b0, 1'b0, "pass_y"};
    vecs[5]  = '{16'h1234, 16'h5678, OP_NOT_Y,   16'hA987, 1'b0, 1'b1, "not_y"};
    vecs[6]  = '{16'h1234, 16'h5678, OP_NEG_Y,   16'hA988, 1'b0, 1'b1, "neg_y"};
    vecs[7]  = '{16'h1234, 16'h5678, OP_Y_INC,   16'h5679, 1'b0, 1'b0, "y_inc"};
    vecs[8]  = '{16'h1234, 16'h5678, OP_X_DEC,   16'h1233, 1'b0, 1'b0, "x_dec"};
    vecs[9]  = '{16'h1234, 16'h5678, OP_Y_DEC,   16'h5677, 1'b0, 1'b0, "y_dec"};
    vecs[10] = '{16'h0005, 16'h0003, OP_ADD,     16'h0008, 1'b0, 1'b0, "add"};
    vecs[11] = '{16'h0005, 16'h0003, OP_X_SUB_Y, 16'h0002, 1'b0, 1'b0, "x_sub_y"};
    vecs[12] = '{16'h0005, 16'h0003, OP_Y_SUB_X, 16'hFFFE, 1'b0, 1'b1, "y_sub_x"};
    vecs[13] = '{16'h00FF, 16'h0F0F, OP_AND,     16'h000F, 1'b0, 1'b0, "and"};
    vecs[14] = '{16'h00FF, 16'h0F0F, OP_OR,      16'h0FFF, 1'b0, 1'b0, "or"};
    vecs[15] = '{16'h00FF, 16'h0F0F, OP_NOT_X,   16'hFF00, 1'b0, 1'b1, "not_x"};
    vecs[16] = '{16'h00FF, 16'h0F0F, OP_NEG_X,   16'hFF01, 1'b0, 1'b1, "neg_x"};
    vecs[17] = '{16'h7FFF, 16'h0000, OP_X_INC,   16'h8000, 1'b0, 1'b1, "inc_7fff"};
    vecs[18] = '{16'hFFFF, 16'h0000, OP_X_INC,   16'h0000, 1'b1, 1'b0, "inc_ffff"};

    // Reset state: registered build forces 0/1/0; combinational 0&0 gives the same.
    repeat (2) @(posedge clk_cpu);
    #1;
    check("reset", 16'h0000, 1'b1, 1'b0);
    @(negedge clk_cpu);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].x, vecs[i].y, vecs[i].c);
      check(vecs[i].name, vecs[i].e_out, vecs[i].e_zr, vecs[i].e_ng);
    end

    for (int c = 0; c < 64; c++) begin
      for (int k = 0; k < 3; k++) begin
        rx = 16'($urandom);
        ry = 16'($urandom);
        if (k == 0) begin
          rx = 16'h0000;
          ry = 16'hFFFF;
        end
        apply(rx, ry, 6'(c));
        m = model(rx, ry, 6'(c));
        check($sformatf("sweep c=%b x=%h y=%h", 6'(c), rx, ry), m, m == 16'h0000, m[15]);
      end
    end

`ifdef HACK_ALU_OUT_REG_EN
    // Previous output is the last sweep result; new inputs must not show before the edge.
    @(negedge clk_cpu);
    drive(16'h0002, 16'h0002, OP_ADD);
    #1;
    total++;
    if (out === 16'h0004) begin
      bad++;
      $display("FAIL reg_latency: got out=%h before edge, want not 0004", out);
    end
    @(posedge clk_cpu);
    #1;
    check("reg_after_edge", 16'h0004, 1'b0, 1'b0);

    @(negedge clk_cpu);
    rst = 1'b1;
    @(posedge clk_cpu);
    #1;
    check("reg_rst_held", 16'h0000, 1'b1, 1'b0);
    @(negedge clk_cpu);
    rst = 1'b0;
    @(posedge clk_cpu);
    #1;
    check("reg_rst_release", 16'h0004, 1'b0, 1'b0);

    // Pending result discarded when reset lands before its capture edge.
    @(negedge clk_cpu);
    drive(16'h0000, 16'h0001, OP_NEG_Y);
    rst = 1'b1;
    @(posedge clk_cpu);
    #1;
    check("reg_rst_discard", 16'h0000, 1'b1, 1'b0);
    @(negedge clk_cpu);
    rst = 1'b0;
    @(posedge clk_cpu);
    #1;
    check("reg_resume", 16'hFFFF, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
